// File: rtl/pulse_param_loader.sv
// Pulse-sequence parameter loader: parses framed UART writes into a shadow
// register set and commits the whole set to the active outputs at a period boundary.
module pulse_param_loader #(
   parameter int TIMEOUT_CYCLES = 500000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_byte,
   input  logic        rx_valid,
   input  logic        period_start,
   output logic [31:0] per,
   output logic [15:0] p1wid,
   output logic [15:0] del,
   output logic [15:0] p2wid,
   output logic [7:0]  nut_w,
   output logic [15:0] nut_d,
   output logic [7:0]  cp,
   output logic [7:0]  p_bl,
   output logic [15:0] p_bl_off,
   output logic        bl,
   output logic        load_strobe,
   output logic        pending,
   output logic        cmd_ok,
   output logic        cmd_err
);

   localparam int NF = 10;
   localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [7:0] SYNC = 8'hA5;

   function automatic int field_width(input int i);
      case (i)
         0:          return 32;
         4, 6, 7:    return 8;
         9:          return 1;
         default:    return 16;
      endcase
   endfunction

   function automatic int field_offset(input int i);
      int sum = 0;
      for (int k = 0; k < i; k++) sum += field_width(k);
      return sum;
   endfunction

   function automatic logic [31:0] field_default(input int i);
      case (i)
         0:       return 32'd4000;
         1:       return 32'd30;
         2:       return 32'd200;
         3:       return 32'd60;
         6:       return 32'd1;
         7:       return 32'd50;
         8:       return 32'd100;
         9:       return 32'd1;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [2:0] byte_len(input logic [3:0] a);
      case (a)
         4'd0:                   return 3'd4;
         4'd4, 4'd6, 4'd7, 4'd9: return 3'd1;
         default:                return 3'd2;
      endcase
   endfunction

   localparam int TOTAL = field_offset(NF);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, CHK} state_t;

   state_t           state_reg, state_next;
   logic [3:0]       addr_reg;
   logic [2:0]       cnt_reg;
   logic [31:0]      asm_reg;
   logic [7:0]       xor_reg;
   logic [GW-1:0]    gap_reg;
   logic [TOTAL-1:0] shadow_reg;
   logic [TOTAL-1:0] active_reg;
   logic             pending_reg, load_strobe_reg, cmd_ok_reg, cmd_err_reg;
   logic             timeout, frame_ok, frame_err, commit;

   always_ff @(posedge clk) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   assign timeout = (state_reg != IDLE) && !rx_valid && (gap_reg == GW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (rx_valid && rx_byte == SYNC) state_next = ADDR;
         ADDR: if (rx_valid) state_next = (rx_byte > 8'd9) ? IDLE : DATA;
         DATA: if (rx_valid && cnt_reg == 3'd1) state_next = CHK;
         CHK:  if (rx_valid) state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (timeout) state_next = IDLE;
   end

   // Timeout only fires on a cycle without rx_valid, so ok and err are exclusive.
   always_comb begin
      frame_ok  = (state_reg == CHK) && rx_valid && (rx_byte == xor_reg);
      frame_err = ((state_reg == ADDR) && rx_valid && (rx_byte > 8'd9))
               || ((state_reg == CHK) && rx_valid && (rx_byte != xor_reg))
               || timeout;
   end

   assign commit = period_start && pending_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         addr_reg        <= '0;
         cnt_reg         <= '0;
         asm_reg         <= '0;
         xor_reg         <= '0;
         gap_reg         <= '0;
         pending_reg     <= 1'b0;
         load_strobe_reg <= 1'b0;
         cmd_ok_reg      <= 1'b0;
         cmd_err_reg     <= 1'b0;
      end else begin
         if (state_reg == IDLE || rx_valid) gap_reg <= '0;
         else                               gap_reg <= gap_reg + GW'(1);
         if (rx_valid && state_reg == ADDR) begin
            addr_reg <= rx_byte[3:0];
            cnt_reg  <= byte_len(rx_byte[3:0]);
            asm_reg  <= '0;
            xor_reg  <= rx_byte;
         end else if (rx_valid && state_reg == DATA) begin
            asm_reg <= {asm_reg[23:0], rx_byte};
            xor_reg <= xor_reg ^ rx_byte;
            cnt_reg <= cnt_reg - 3'd1;
         end
         // A write landing on the commit cycle keeps pending set for the next period.
         if (frame_ok)    pending_reg <= 1'b1;
         else if (commit) pending_reg <= 1'b0;
         load_strobe_reg <= commit;
         cmd_ok_reg      <= frame_ok;
         cmd_err_reg     <= frame_err;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NF; gi++) begin : g_field
         localparam int          W = field_width(gi);
         localparam int          O = field_offset(gi);
         localparam logic [31:0] D = field_default(gi);
         always_ff @(posedge clk) begin
            if (reset) begin
               shadow_reg[O +: W] <= D[W-1:0];
               active_reg[O +: W] <= D[W-1:0];
            end else begin
               if (frame_ok && addr_reg == 4'(gi)) shadow_reg[O +: W] <= asm_reg[W-1:0];
               if (commit) active_reg[O +: W] <= shadow_reg[O +: W];
            end
         end
      end
   endgenerate

   assign per         = active_reg[field_offset(0) +: 32];
   assign p1wid       = active_reg[field_offset(1) +: 16];
   assign del         = active_reg[field_offset(2) +: 16];
   assign p2wid       = active_reg[field_offset(3) +: 16];
   assign nut_w       = active_reg[field_offset(4) +: 8];
   assign nut_d       = active_reg[field_offset(5) +: 16];
   assign cp          = active_reg[field_offset(6) +: 8];
   assign p_bl        = active_reg[field_offset(7) +: 8];
   assign p_bl_off    = active_reg[field_offset(8) +: 16];
   assign bl          = active_reg[field_offset(9)];
   assign load_strobe = load_strobe_reg;
   assign pending     = pending_reg;
   assign cmd_ok      = cmd_ok_reg;
   assign cmd_err     = cmd_err_reg;

endmodule

// File: tb/tb_pulse_param_loader.sv
// Directed bench for pulse_param_loader: table of frames with commit checks,
// plus timeout, same-cycle collision, batch update and mid-frame reset sequences.
module tb_pulse_param_loader;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        reset, rx_valid, period_start;
   logic [7:0]  rx_byte;
   logic [31:0] per;
   logic [15:0] p1wid, del, p2wid, nut_d, p_bl_off;
   logic [7:0]  nut_w, cp, p_bl;
   logic        bl, load_strobe, pending, cmd_ok, cmd_err;

   int tests = 0, fails = 0;
   int ok_cnt = 0, err_cnt = 0, ls_cnt = 0;
   bit both_seen = 1'b0;

   pulse_param_loader #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_valid(rx_valid),
      .period_start(period_start), .per(per), .p1wid(p1wid), .del(del),
      .p2wid(p2wid), .nut_w(nut_w), .nut_d(nut_d), .cp(cp), .p_bl(p_bl),
      .p_bl_off(p_bl_off), .bl(bl), .load_strobe(load_strobe),
      .pending(pending), .cmd_ok(cmd_ok), .cmd_err(cmd_err)
   );

   always #10 clk = ~clk;

   always @(negedge clk) begin
      if (cmd_ok)  ok_cnt++;
      if (cmd_err) err_cnt++;
      if (load_strobe) ls_cnt++;
      if (cmd_ok && cmd_err) both_seen = 1'b1;
   end

   typedef struct {
      logic [63:0] bytes;
      int          n;
      int          exp_ok;
      int          exp_err;
      logic        exp_pend;
      int          fld;
      logic [31:0] exp_val;
   } vec_t;

   vec_t vecs [10];
   logic [31:0] defaults [10] = '{32'd4000, 32'd30, 32'd200, 32'd60, 32'd0,
                                  32'd0, 32'd1, 32'd50, 32'd100, 32'd1};

   function automatic logic [31:0] get_field(input int f);
      case (f)
         0: return per;
         1: return {16'd0, p1wid};
         2: return {16'd0, del};
         3: return {16'd0, p2wid};
         4: return {24'd0, nut_w};
         5: return {16'd0, nut_d};
         6: return {24'd0, cp};
         7: return {24'd0, p_bl};
         8: return {16'd0, p_bl_off};
         default: return {31'd0, bl};
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_byte  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [63:0] bytes, input int n);
      logic [63:0] tmp;
      tmp = bytes;
      for (int i = 0; i < n; i++) send_byte(tmp[63-8*i -: 8]);
      repeat (2) @(negedge clk);
   endtask

   task automatic pulse_period();
      @(negedge clk);
      period_start = 1'b1;
      @(negedge clk);
      period_start = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic check_defaults(input string tag);
      for (int f = 0; f < 10; f++)
         check($sformatf("%s_field%0d", tag, f), get_field(f), defaults[f]);
      check({tag, "_pending"}, {31'd0, pending}, 32'd0);
   endtask

   initial begin
      int ok0, err0, ls0, n;
      vecs[0] = '{64'hA5010028_29000000, 5, 1, 0, 1'b1, 1, 32'd40};
      vecs[1] = '{64'hA5000000_0FA00000, 7, 0, 1, 1'b0, 0, 32'd4000};
      vecs[2] = '{64'hA50C0000_00000000, 2, 0, 1, 1'b0, 0, 32'd4000};
      vecs[3] = '{64'hA5030064_67000000, 5, 1, 0, 1'b1, 3, 32'd100};
      vecs[4] = '{64'h1122A504_7F7B0000, 6, 1, 0, 1'b1, 4, 32'd127};
      vecs[5] = '{64'hA5000001_86A02700, 7, 1, 0, 1'b1, 0, 32'd100000};
      vecs[6] = '{64'hA509020B_00000000, 4, 1, 0, 1'b1, 9, 32'd0};
      vecs[7] = '{64'hA5051234_23000000, 5, 1, 0, 1'b1, 5, 32'h1234};
      vecs[8] = '{64'hA50801F4_FD000000, 5, 1, 0, 1'b1, 8, 32'd500};
      vecs[9] = '{64'hA507FFF8_00000000, 4, 1, 0, 1'b1, 7, 32'd255};

      reset = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00; period_start = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_defaults("reset");
      check("reset_flags", {29'd0, load_strobe, cmd_ok, cmd_err}, 32'd0);

      for (int v = 0; v < 10; v++) begin
         ok0 = ok_cnt; err0 = err_cnt;
         send_frame(vecs[v].bytes, vecs[v].n);
         check($sformatf("v%0d_ok", v), ok_cnt - ok0, vecs[v].exp_ok);
         check($sformatf("v%0d_err", v), err_cnt - err0, vecs[v].exp_err);
         check($sformatf("v%0d_pending", v), {31'd0, pending}, {31'd0, vecs[v].exp_pend});
         if (vecs[v].exp_pend)
            check($sformatf("v%0d_precommit", v), get_field(vecs[v].fld) == vecs[v].exp_val, 0);
         ls0 = ls_cnt;
         pulse_period();
         check($sformatf("v%0d_field", v), get_field(vecs[v].fld), vecs[v].exp_val);
         check($sformatf("v%0d_strobe", v), ls_cnt - ls0, vecs[v].exp_pend ? 1 : 0);
         check($sformatf("v%0d_pend_clr", v), {31'd0, pending}, 32'd0);
      end
      $display("[TB] vector table done");

      // Timeout after a partial frame, then a clean write
      err0 = err_cnt;
      send_byte(8'hA5); send_byte(8'h03); send_byte(8'h00);
      n = 0;
      while (!cmd_err && n < TO + 10) begin
         @(negedge clk);
         n++;
      end
      check("timeout_cycles", n, TO);
      repeat (2) @(negedge clk);
      check("timeout_err", err_cnt - err0, 1);
      ok0 = ok_cnt;
      send_frame(64'hA50300C8_CB000000, 5);
      check("post_timeout_ok", ok_cnt - ok0, 1);
      pulse_period();
      check("post_timeout_p2wid", {16'd0, p2wid}, 32'd200);
      $display("[TB] timeout sequence done");

      // Checksum byte coincides with a commit of an earlier write
      send_frame(64'hA502012C_2F000000, 5);
      send_byte(8'hA5); send_byte(8'h06); send_byte(8'h03);
      ls0 = ls_cnt;
      @(negedge clk);
      rx_byte = 8'h05; rx_valid = 1'b1; period_start = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0; period_start = 1'b0;
      repeat (2) @(negedge clk);
      check("collide_del", {16'd0, del}, 32'd300);
      check("collide_cp_old", {24'd0, cp}, 32'd1);
      check("collide_pending", {31'd0, pending}, 32'd1);
      check("collide_strobe", ls_cnt - ls0, 1);
      pulse_period();
      check("collide_cp_new", {24'd0, cp}, 32'd3);
      check("collide_pend_clr", {31'd0, pending}, 32'd0);
      $display("[TB] collision sequence done");

      // Batch of two writes, one with period_start mid-frame
      ok0 = ok_cnt;
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
      pulse_period();
      send_frame(64'hFAF80000_00000000, 2);
      send_frame(64'hA5040A0E_00000000, 4);
      check("batch_ok", ok_cnt - ok0, 2);
      check("batch_del_hold", {16'd0, del}, 32'd300);
      ls0 = ls_cnt;
      @(negedge clk);
      period_start = 1'b1;
      @(negedge clk);
      period_start = 1'b0;
      check("batch_same_cycle", {del == 16'd250, nut_w == 8'd10}, 32'd3);
      repeat (2) @(negedge clk);
      check("batch_strobe", ls_cnt - ls0, 1);
      $display("[TB] batch sequence done");

      // Reset in mid-frame with a pending write outstanding
      send_frame(64'hA5010063_62000000, 5);
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_defaults("midreset");
      ok0 = ok_cnt;
      send_frame(64'hA5040A0E_00000000, 4);
      check("midreset_ok", ok_cnt - ok0, 1);
      pulse_period();
      check("midreset_nut_w", {24'd0, nut_w}, 32'd10);
      check("midreset_p1wid", {16'd0, p1wid}, 32'd30);
      $display("[TB] mid-frame reset sequence done");

      check("ok_err_exclusive", {31'd0, both_seen}, 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not complete, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
